// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-side blocks.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    START     = 3'd2,
    REQ       = 3'd3,
    DATA      = 3'd4,
    ACK       = 3'd5,
    WAIT_IDLE = 3'd6
  } ps2_tx_state_e;

  localparam int PS2_FRAME_FALLS = 11;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ECHO    = 8'hEE;

  // PS/2 frames carry odd parity over the eight data bits.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~(^d);
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a host controller and ps2_host_tx.
interface ps2_host_tx_if;
  logic [7:0] data;
  logic       send;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       timeout;

  modport master (output data, output send, input busy, input done, input ack_err, input timeout);
  modport slave  (input data, input send, output busy, output done, output ack_err, output timeout);
endinterface

// File: rtl/ps2_edge_sync.sv
// Three-flop synchroniser for one PS/2 pad line with edge detection.
module ps2_edge_sync (
  input  logic clk,
  input  logic clrn,
  input  logic din,
  output logic level,
  output logic fall,
  output logic rise
);

  logic [2:0] sync_r;

  // Shift the pad value through the synchroniser; idle lines read high.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      sync_r <= 3'b111;
    end else begin
      sync_r <= {sync_r[1:0], din};
    end
  end

  assign level = sync_r[1];
  assign fall  = sync_r[2] & ~sync_r[1];
  assign rise  = ~sync_r[2] & sync_r[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter driving open-drain pad enables.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int CNT_W          = 20
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          ps2_clk,
  input  logic          ps2_data,
  output logic          ps2_clk_oe,
  output logic          ps2_data_oe,
  ps2_host_tx_if.slave  bus
);

  localparam logic [3:0]       STOP_FALL_IDX = 4'(PS2_FRAME_FALLS - 2);
  localparam logic [CNT_W-1:0] INH_LAST      = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST      = CNT_W'(TIMEOUT_CYCLES - 1);

  ps2_tx_state_e    state_r, state_nxt_s;
  logic [8:0]       shreg_r, shreg_nxt_s;
  logic [3:0]       bitcnt_r, bitcnt_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             clk_oe_r, clk_oe_nxt_s;
  logic             data_oe_r, data_oe_nxt_s;
  logic             busy_r, busy_nxt_s;
  logic             done_r, done_nxt_s;
  logic             ack_err_r, ack_err_nxt_s;
  logic             ack_smp_r, ack_smp_nxt_s;
  logic             timeout_r, timeout_nxt_s;

  logic clk_level_s, clk_fall_s, clk_rise_s;
  logic data_level_s, data_fall_s, data_rise_s;
  logic timed_s, dev_edge_s, unused_s;

  ps2_edge_sync u_clk_sync (
    .clk(clk), .clrn(clrn), .din(ps2_clk),
    .level(clk_level_s), .fall(clk_fall_s), .rise(clk_rise_s)
  );

  ps2_edge_sync u_data_sync (
    .clk(clk), .clrn(clrn), .din(ps2_data),
    .level(data_level_s), .fall(data_fall_s), .rise(data_rise_s)
  );

  assign unused_s = data_fall_s ^ data_rise_s;

  assign timed_s = (state_r == REQ) || (state_r == DATA) || (state_r == ACK) || (state_r == WAIT_IDLE);
  // The rise seen in REQ is our own release of ps2_clk, not device activity.
  assign dev_edge_s = clk_fall_s | (clk_rise_s & (state_r != REQ));

  // State and registered-output update.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_r   <= IDLE;
      shreg_r   <= 9'h000;
      bitcnt_r  <= 4'd0;
      cnt_r     <= {CNT_W{1'b0}};
      clk_oe_r  <= 1'b0;
      data_oe_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      ack_err_r <= 1'b0;
      ack_smp_r <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      shreg_r   <= shreg_nxt_s;
      bitcnt_r  <= bitcnt_nxt_s;
      cnt_r     <= cnt_nxt_s;
      clk_oe_r  <= clk_oe_nxt_s;
      data_oe_r <= data_oe_nxt_s;
      busy_r    <= busy_nxt_s;
      done_r    <= done_nxt_s;
      ack_err_r <= ack_err_nxt_s;
      ack_smp_r <= ack_smp_nxt_s;
      timeout_r <= timeout_nxt_s;
    end
  end

  // Frame sequencing, bit shifting and the per-edge watchdog.
  always_comb begin
    state_nxt_s   = state_r;
    shreg_nxt_s   = shreg_r;
    bitcnt_nxt_s  = bitcnt_r;
    cnt_nxt_s     = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    clk_oe_nxt_s  = clk_oe_r;
    data_oe_nxt_s = data_oe_r;
    busy_nxt_s    = busy_r;
    done_nxt_s    = 1'b0;
    ack_err_nxt_s = 1'b0;
    ack_smp_nxt_s = ack_smp_r;
    timeout_nxt_s = 1'b0;

    case (state_r)
      IDLE: begin
        clk_oe_nxt_s  = 1'b0;
        data_oe_nxt_s = 1'b0;
        busy_nxt_s    = 1'b0;
        cnt_nxt_s     = {CNT_W{1'b0}};
        if (bus.send) begin
          state_nxt_s  = INHIBIT;
          shreg_nxt_s  = {odd_parity(bus.data), bus.data};
          bitcnt_nxt_s = 4'd0;
          clk_oe_nxt_s = 1'b1;
          busy_nxt_s   = 1'b1;
        end else begin
          state_nxt_s  = IDLE;
        end
      end
      INHIBIT: begin
        if (cnt_r == INH_LAST) begin
          state_nxt_s   = START;
          data_oe_nxt_s = 1'b1;
          cnt_nxt_s     = {CNT_W{1'b0}};
        end else begin
          state_nxt_s   = INHIBIT;
        end
      end
      START: begin
        state_nxt_s  = REQ;
        clk_oe_nxt_s = 1'b0;
        cnt_nxt_s    = {CNT_W{1'b0}};
      end
      REQ, DATA: begin
        if (clk_fall_s) begin
          bitcnt_nxt_s = bitcnt_r + 4'd1;
          if (bitcnt_r == STOP_FALL_IDX) begin
            data_oe_nxt_s = 1'b0;
            state_nxt_s   = ACK;
          end else begin
            data_oe_nxt_s = ~shreg_r[0];
            shreg_nxt_s   = {1'b0, shreg_r[8:1]};
            state_nxt_s   = DATA;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      ACK: begin
        if (clk_fall_s) begin
          ack_smp_nxt_s = data_level_s;
          bitcnt_nxt_s  = bitcnt_r + 4'd1;
          state_nxt_s   = WAIT_IDLE;
        end else begin
          state_nxt_s   = ACK;
        end
      end
      WAIT_IDLE: begin
        if (clk_level_s && data_level_s) begin
          done_nxt_s    = 1'b1;
          ack_err_nxt_s = ack_smp_r;
          state_nxt_s   = IDLE;
        end else begin
          state_nxt_s   = WAIT_IDLE;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        clk_oe_nxt_s  = 1'b0;
        data_oe_nxt_s = 1'b0;
        busy_nxt_s    = 1'b0;
      end
    endcase

    // A device edge restarts the watchdog and always beats expiry.
    if (timed_s) begin
      if (dev_edge_s) begin
        cnt_nxt_s = {CNT_W{1'b0}};
      end else if ((cnt_r == TMO_LAST) && (state_nxt_s == state_r)) begin
        clk_oe_nxt_s  = 1'b0;
        data_oe_nxt_s = 1'b0;
        timeout_nxt_s = 1'b1;
        state_nxt_s   = IDLE;
      end else begin
        timeout_nxt_s = 1'b0;
      end
    end else begin
      timeout_nxt_s = 1'b0;
    end
  end

  assign ps2_clk_oe  = clk_oe_r;
  assign ps2_data_oe = data_oe_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.ack_err = ack_err_r;
  assign bus.timeout = timeout_r;

endmodule
